frame_capture_gate: RTL and testbench
=====================================

// Module: frame_capture_gate
// PURPOSE
//  Gates the raw camera pixel stream (FVAL/LVAL/DATA) using the stop level from stop_handler (oStop -> iStop).
//  Frames are admitted only whole: capture starts on a frame-valid rising edge while not stopped.
//  A stop raised mid-frame takes effect at that frame's end.
//  Emits qualified pixels with X/Y coordinates, plus a frame counter and frame-done/frozen status for the SDRAM writer.
// PARAMETERS
//  DATA_W   12  pixel data width
//  X_W      12  column counter width (saturates at 2^X_W-1)
//  Y_W      11  row counter width (saturates at 2^Y_W-1)
//  FRAME_W  16  frame counter width (wraps)
// PORTS
//  iCLK        in   1        pixel clock; all logic on rising edge
//  iRST        in   1        asynchronous, active-high reset
//  iStop       in   1        level; 1 = stop admitting new frames (from stop_handler oStop)
//  iFVAL       in   1        camera frame valid
//  iLVAL       in   1        camera line valid
//  iDATA       in   DATA_W   camera pixel data
//  oDVAL       out  1        qualified pixel valid
//  oDATA       out  DATA_W   qualified pixel data
//  oX          out  X_W      column of current oDATA
//  oY          out  Y_W      row of current oDATA
//  oFrameCnt   out  FRAME_W  completed frame count
//  oFrameDone  out  1        1-cycle pulse at end of each admitted frame
//  oFrozen     out  1        1 while halted after a stopped frame end
//  oOverflow   out  1        sticky; X or Y counter saturated in some frame
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; FVAL/LVAL delay registers 0.
//  Edge detection: registered iFVAL_d/iLVAL_d.
//   SOF = iFVAL & ~iFVAL_d;  EOF = ~iFVAL & iFVAL_d;  EOL = ~iLVAL & iLVAL_d.
//  FSM:
//   IDLE   - SOF & ~iStop -> ACTIVE; X<=0, Y<=0.
//            SOF & iStop -> FROZEN.
//            A frame already in progress on entry is never admitted; only a new SOF starts capture.
//   ACTIVE - Each cycle with iFVAL & iLVAL:
//              oDVAL<=1, oDATA<=iDATA, oX<=X, oY<=Y, X<=X+1.
//            Otherwise oDVAL<=0.
//            On EOL: X<=0, Y<=Y+1.
//            On EOF: oFrameDone<=1, oFrameCnt<=oFrameCnt+1 (wraps);
//              next state is FROZEN if iStop else IDLE.
//            iStop during ACTIVE is ignored until EOF.
//   FROZEN - oFrozen=1, oDVAL=0.
//            ~iStop -> IDLE (then waits for next SOF).
//            iStop held permanently -> stays FROZEN.
//  Latency: exactly 1 cycle from iDATA sample to oDVAL/oDATA/oX/oY.
//  Saturation: X at all-ones stays there and sets oOverflow; same rule for Y.
//   oOverflow is cleared only by reset.
//  Simultaneous events:
//   - EOF and SOF cannot coincide (one-cycle FVAL low is still an EOF).
//   - EOL and EOF in the same cycle: both count, Y increment is irrelevant.
//   - iStop rising in the same cycle as SOF in IDLE -> FROZEN; frame not admitted.
//  Reset mid-frame: everything returns to reset values immediately.
//   After reset release, capture resumes at the next SOF; the partial frame is dropped.
// STRUCTURE
//  Package capture_pkg: state encoding localparams IDLE=2'd0, ACTIVE=2'd1, FROZEN=2'd2; DATA_W/X_W/Y_W defaults.
//  Sub-module capture_edge_det: registers iFVAL/iLVAL and outputs SOF/EOF/EOL.
//  FSM, counters and output registers stay in frame_capture_gate.
// TESTING
//  1. Reset, iStop=0, 4x3 frame (LVAL 4 cycles, 2 gaps) -> 12 oDVAL beats, last at X=3,Y=2; oFrameDone once; oFrameCnt=1.
//  2. iStop=1 mid-frame 1 -> frame 1 completes fully; after EOF oFrozen=1; frame 2 gives no oDVAL; oFrameCnt=1.
//  3. Release iStop while FVAL high -> no oDVAL in that frame; next SOF captures; oFrozen=0 from the cycle after release.
//  4. X_W=3, 10-pixel line -> oX sticks at 7, oOverflow=1 and stays 1 through later frames.
//  5. Assert iRST in row 1 of a frame -> all outputs 0 asynchronously; after release, no oDVAL until the next SOF.
//  6. FRAME_W=2, 5 frames with iStop=0 -> oFrameCnt sequence 1,2,3,0,1; exactly 5 oFrameDone pulses.

Source files
------------

// File: rtl/capture_pkg.sv
// Purpose: shared FSM encoding and width defaults for the frame capture gate.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package capture_pkg;

  localparam int DATA_W_DEF  = 12;
  localparam int X_W_DEF     = 12;
  localparam int Y_W_DEF     = 11;
  localparam int FRAME_W_DEF = 16;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] FROZEN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_ACTIVE = ACTIVE,
    ST_FROZEN = FROZEN
  } state_t;

endpackage

// File: rtl/capture_edge_det.sv
// Purpose: registers FVAL/LVAL and flags start-of-frame, end-of-frame, end-of-line.
// Latency: flags are combinational on the current input against the 1-cycle delayed copy.
// Backpressure: none; the camera stream cannot be stalled.
module capture_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic fval,
  input  logic lval,
  output logic sof,
  output logic eof,
  output logic eol
);

  logic fval_d;
  logic lval_d;
  // armed goes high once FVAL has been seen low, so a frame already running
  // when reset releases never looks like a fresh start-of-frame.
  logic armed;

  // Delay registers and the arm flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fval_d <= 1'b0;
      lval_d <= 1'b0;
      armed  <= 1'b0;
    end else begin
      fval_d <= fval;
      lval_d <= lval;
      armed  <= armed | ~fval;
    end
  end

  assign sof = fval & ~fval_d & armed;
  assign eof = ~fval & fval_d;
  assign eol = ~lval & lval_d;

endmodule

// File: rtl/frame_capture_gate.sv
// Purpose: admits whole camera frames while not stopped, tagging pixels with X/Y and counting frames.
// Latency: 1 cycle from iDATA sample to oDVAL/oDATA/oX/oY.
// Backpressure: none; a stop only blocks the next frame, the current frame always completes.
module frame_capture_gate
  import capture_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int X_W     = X_W_DEF,
  parameter int Y_W     = Y_W_DEF,
  parameter int FRAME_W = FRAME_W_DEF
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iStop,
  input  logic               iFVAL,
  input  logic               iLVAL,
  input  logic [DATA_W-1:0]  iDATA,
  output logic               oDVAL,
  output logic [DATA_W-1:0]  oDATA,
  output logic [X_W-1:0]     oX,
  output logic [Y_W-1:0]     oY,
  output logic [FRAME_W-1:0] oFrameCnt,
  output logic               oFrameDone,
  output logic               oFrozen,
  output logic               oOverflow
);

  localparam logic [X_W-1:0] X_MAX = '1;
  localparam logic [Y_W-1:0] Y_MAX = '1;

  state_t         state;
  state_t         state_nxt;
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;
  logic           sof;
  logic           eof;
  logic           eol;
  logic           pix;

  capture_edge_det u_edge (
    .clk  (iCLK),
    .rst  (iRST),
    .fval (iFVAL),
    .lval (iLVAL),
    .sof  (sof),
    .eof  (eof),
    .eol  (eol)
  );

  assign pix     = iFVAL & iLVAL;
  assign oFrozen = (state == ST_FROZEN);

  // State register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state: admit on SOF when not stopped, sample the stop again at frame end.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (sof) state_nxt = iStop ? ST_FROZEN : ST_ACTIVE;
      ST_ACTIVE: if (eof) state_nxt = iStop ? ST_FROZEN : ST_IDLE;
      ST_FROZEN: if (!iStop) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Coordinate counters, qualified pixel outputs, frame counter and overflow flag.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      oDVAL      <= 1'b0;
      oDATA      <= '0;
      oX         <= '0;
      oY         <= '0;
      oFrameCnt  <= '0;
      oFrameDone <= 1'b0;
      oOverflow  <= 1'b0;
    end else begin
      oDVAL      <= 1'b0;
      oFrameDone <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sof && !iStop) begin
            x_cnt <= '0;
            y_cnt <= '0;
          end
        end
        ST_ACTIVE: begin
          // pix and eol are mutually exclusive (pix needs LVAL high), so x_cnt has one writer per cycle.
          if (pix) begin
            oDVAL <= 1'b1;
            oDATA <= iDATA;
            oX    <= x_cnt;
            oY    <= y_cnt;
            if (x_cnt == X_MAX) oOverflow <= 1'b1;
            else                x_cnt     <= x_cnt + 1'b1;
          end
          if (eol) begin
            x_cnt <= '0;
            if (y_cnt == Y_MAX) oOverflow <= 1'b1;
            else                y_cnt     <= y_cnt + 1'b1;
          end
          if (eof) begin
            oFrameDone <= 1'b1;
            oFrameCnt  <= oFrameCnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_capture_gate.sv
module tb_frame_capture_gate;

  localparam int DW   = 12;
  localparam int XW   = 3;
  localparam int YW   = 3;
  localparam int FW   = 2;
  localparam int XMAX = (1 << XW) - 1;
  localparam int YMAX = (1 << YW) - 1;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b1;
  logic          iStop = 1'b0;
  logic          iFVAL = 1'b0;
  logic          iLVAL = 1'b0;
  logic [DW-1:0] iDATA = '0;
  logic          oDVAL;
  logic [DW-1:0] oDATA;
  logic [XW-1:0] oX;
  logic [YW-1:0] oY;
  logic [FW-1:0] oFrameCnt;
  logic          oFrameDone;
  logic          oFrozen;
  logic          oOverflow;

  always #5 iCLK = ~iCLK;

  frame_capture_gate #(.DATA_W(DW), .X_W(XW), .Y_W(YW), .FRAME_W(FW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iStop(iStop), .iFVAL(iFVAL), .iLVAL(iLVAL), .iDATA(iDATA),
    .oDVAL(oDVAL), .oDATA(oDATA), .oX(oX), .oY(oY), .oFrameCnt(oFrameCnt),
    .oFrameDone(oFrameDone), .oFrozen(oFrozen), .oOverflow(oOverflow)
  );

  typedef struct { int cyc; logic [DW-1:0] data; int x; int y; logic ovf; } px_t;
  typedef struct { int cyc; int cnt; } dn_t;
  typedef struct { int cyc; logic fz; } fz_t;

  px_t px_q[$];
  dn_t dn_q[$];
  fz_t fz_q[$];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int done_seen = 0;

  // Reference model: stream-level view of frames and the stop level.
  logic m_prev_f, m_prev_l, m_armed, m_halt, m_cap, m_ovf;
  int   m_line, m_pix, m_cnt;
  logic cur_stop = 1'b0;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one input cycle and advance the reference model.
  task automatic step(input logic f, input logic l, input logic s, input logic r = 1'b0);
    logic sof, eof, eol;
    px_t  pe;
    dn_t  de;
    fz_t  fe;
    @(posedge iCLK); #1;
    iRST = r; iFVAL = f; iLVAL = l; iStop = s; iDATA = DW'($urandom);
    if (r) begin
      px_q.delete(); dn_q.delete(); fz_q.delete();
      m_prev_f = 0; m_prev_l = 0; m_armed = 0; m_halt = 0; m_cap = 0; m_ovf = 0;
      m_cnt = 0; m_line = 0; m_pix = 0;
    end else begin
      sof = f & ~m_prev_f;
      eof = ~f & m_prev_f;
      eol = ~l & m_prev_l;
      if (!m_cap) begin
        if (m_halt) begin
          if (!s) m_halt = 0;
        end else if (sof && m_armed) begin
          if (s) m_halt = 1;
          else begin m_cap = 1; m_line = 0; m_pix = 0; end
        end
      end else begin
        if (f && l) begin
          if (m_pix >= XMAX) m_ovf = 1;
          pe.cyc = cyc + 1; pe.data = iDATA;
          pe.x = (m_pix > XMAX) ? XMAX : m_pix;
          pe.y = (m_line > YMAX) ? YMAX : m_line;
          pe.ovf = m_ovf;
          px_q.push_back(pe);
          m_pix++;
        end
        if (eol) begin
          if (m_line >= YMAX) m_ovf = 1;
          m_line++; m_pix = 0;
        end
        if (eof) begin
          m_cnt = (m_cnt + 1) % (1 << FW);
          de.cyc = cyc + 1; de.cnt = m_cnt;
          dn_q.push_back(de);
          m_cap = 0;
          m_halt = s;
        end
      end
      m_armed = m_armed | ~f;
      m_prev_f = f;
      m_prev_l = l;
      fe.cyc = cyc + 1; fe.fz = m_halt;
      fz_q.push_back(fe);
    end
  endtask

  // One frame of nl lines x ppl pixels; stop level changes to sv at the start of line sl.
  task automatic frame(input int nl, input int ppl, input int sl, input logic sv);
    step(1, 0, cur_stop);
    for (int ln = 0; ln < nl; ln++) begin
      if (ln == sl) cur_stop = sv;
      for (int p = 0; p < ppl; p++) step(1, 1, cur_stop);
      repeat ($urandom_range(1, 3)) step(1, 0, cur_stop);
    end
    repeat ($urandom_range(2, 4)) step(0, 0, cur_stop);
  endtask

  // Monitor: compare DUT outputs against the scoreboard queues.
  always @(negedge iCLK) begin
    logic exp_dv, exp_dn;
    px_t  pe;
    dn_t  de;
    fz_t  fe;
    if (iRST) begin
      chk("reset outputs", {oDVAL, oDATA, oX, oY, oFrameCnt, oFrameDone, oFrozen, oOverflow}, 64'd0);
    end else begin
      exp_dv = (px_q.size() > 0) && (px_q[0].cyc == cyc);
      chk("pixel valid", oDVAL, exp_dv);
      if (exp_dv) begin
        pe = px_q.pop_front();
        if (oDVAL) begin
          chk("pixel data", oDATA, pe.data);
          chk("pixel x", oX, pe.x);
          chk("pixel y", oY, pe.y);
          chk("overflow at beat", oOverflow, pe.ovf);
        end
      end
      exp_dn = (dn_q.size() > 0) && (dn_q[0].cyc == cyc);
      chk("frame done pulse", oFrameDone, exp_dn);
      if (oFrameDone) done_seen++;
      if (exp_dn) begin
        de = dn_q.pop_front();
        if (oFrameDone) chk("frame count", oFrameCnt, de.cnt);
      end
      if ((fz_q.size() > 0) && (fz_q[0].cyc == cyc)) begin
        fe = fz_q.pop_front();
        chk("frozen", oFrozen, fe.fz);
      end
    end
  end

  initial begin
    int d0, nl, sl;
    // 1: reset then a plain 4x3 frame
    repeat (3) step(0, 0, 0, 1'b1);
    repeat (2) step(0, 0, 0);
    frame(3, 4, -1, 1'b0);
    @(negedge iCLK);
    chk("count after first frame", oFrameCnt, 1);

    // 2: stop raised mid-frame; that frame completes, the next one is blocked
    frame(3, 4, 1, 1'b1);
    @(negedge iCLK);
    chk("frozen after stopped frame end", oFrozen, 1'b1);
    frame(3, 4, -1, 1'b1);
    @(negedge iCLK);
    chk("count unchanged while frozen", oFrameCnt, m_cnt);

    // 3: release the stop while FVAL is high; only the following frame captures
    frame(3, 4, 1, 1'b0);
    @(negedge iCLK);
    chk("released after stop drop", oFrozen, 1'b0);
    frame(2, 3, -1, 1'b0);

    // 4: 10-pixel line saturates X; overflow stays set
    frame(2, 10, -1, 1'b0);
    frame(2, 3, -1, 1'b0);
    @(negedge iCLK);
    chk("overflow sticky", oOverflow, 1'b1);

    // 5: reset during row 1; the rest of that frame is dropped
    step(1, 0, 0);
    for (int p = 0; p < 4; p++) step(1, 1, 0);
    repeat (2) step(1, 0, 0);
    repeat (2) step(1, 1, 0);
    repeat (2) step(1, 1, 0, 1'b1);
    repeat (2) step(1, 1, 0);
    repeat (2) step(1, 0, 0);
    for (int p = 0; p < 4; p++) step(1, 1, 0);
    repeat (2) step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    @(negedge iCLK);
    chk("no frame counted after reset", oFrameCnt, 0);
    chk("overflow cleared by reset", oOverflow, 1'b0);

    // 6: five frames wrap the 2-bit counter 1,2,3,0,1
    d0 = done_seen;
    for (int k = 0; k < 5; k++) frame(2, 3, -1, 1'b0);
    @(negedge iCLK);
    chk("done pulses in five frames", done_seen - d0, 5);
    chk("count after wrap", oFrameCnt, 1);

    // 7: randomized frames and stop activity
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0) cur_stop = ~cur_stop;
      nl = $urandom_range(1, 4);
      sl = $urandom_range(0, nl);
      frame(nl, $urandom_range(1, 6), sl, 1'($urandom_range(0, 1)));
    end
    cur_stop = 1'b0;
    repeat (4) step(0, 0, 0);
    @(negedge iCLK);
    chk("pixel queue drained", px_q.size(), 0);
    chk("done queue drained", dn_q.size(), 0);
    chk("final frame count", oFrameCnt, m_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
